// File: rtl/if_id_queue_pkg.sv
// Shared CPU constants for the fetch/decode boundary.
// Holds the NOP encoding, the fetch entry layout and the legal queue depths.
package if_id_queue_pkg;

    localparam logic [31:0] NOP_WORD  = 32'h0000_0000;
    localparam int          ENTRY_W   = 96;
    localparam int          DEPTH_MIN = 2;
    localparam int          DEPTH_MAX = 4;

    // One fetched word together with its PC+4 / PC+8 companions.
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc4;
        logic [31:0] pc8;
    } entry_t;

    // Pointer width for a legal depth (2 -> 1 bit, 4 -> 2 bits).
    function automatic int ptr_width(input int depth);
        return (depth > DEPTH_MIN) ? 2 : 1;
    endfunction

endpackage

// File: rtl/if_id_queue_if.sv
// Fetch-to-decode handshake bundle.
// The master side is the fetch/decode pair; the slave side is the queue.
interface if_id_queue_if;

    logic [31:0] Instruction;
    logic [31:0] PC_plus_4;
    logic [31:0] PC_plus_8;
    logic        in_valid;
    logic        in_ready;
    logic        flush;
    logic [31:0] Instr_D;
    logic [31:0] PC_plus_4_D;
    logic [31:0] PC_plus_8_D;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  count;

    modport master (
        output Instruction, PC_plus_4, PC_plus_8, in_valid, flush, out_ready,
        input  in_ready, Instr_D, PC_plus_4_D, PC_plus_8_D, out_valid, count
    );

    modport slave (
        input  Instruction, PC_plus_4, PC_plus_8, in_valid, flush, out_ready,
        output in_ready, Instr_D, PC_plus_4_D, PC_plus_8_D, out_valid, count
    );

endinterface

// File: rtl/if_id_entry_ram.sv
// Entry storage for the fetch queue: DEPTH x 96-bit registers,
// one synchronous write port and one asynchronous read port.
module if_id_entry_ram
    import if_id_queue_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int AW    = 1
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  entry_t        i_wdata,
    input  logic [AW-1:0] i_raddr,
    output entry_t        o_rdata
);

    entry_t r_mem [DEPTH];

    // Write the addressed entry; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/if_id_queue.sv
// Fetch/decode decoupling queue with valid/ready on both sides.
// Head is read straight from storage; empty shows NOP with zero PCs.
module if_id_queue
    import if_id_queue_pkg::*;
#(
    parameter int          DEPTH = 2,
    parameter logic [31:0] NOP   = NOP_WORD
) (
    input logic        clk,
    input logic        reset,
    if_id_queue_if.slave bus
);

    localparam int           AW      = ptr_width(DEPTH);
    localparam logic [2:0]   DEPTH_C = 3'(DEPTH);
    localparam logic [AW-1:0] LAST   = AW'(DEPTH - 1);

    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [2:0]    r_count;

    logic   w_full;
    logic   w_empty;
    logic   w_push;
    logic   w_pop;
    entry_t w_wdata;
    entry_t w_rdata;

    // Ready depends only on the registered count, never on out_ready,
    // so a full queue refuses a push even in a cycle that pops.
    assign w_full  = (r_count == DEPTH_C);
    assign w_empty = (r_count == 3'd0);
    assign w_push  = bus.in_valid & ~w_full & ~bus.flush;
    assign w_pop   = bus.out_ready & ~w_empty & ~bus.flush;

    assign w_wdata.instr = bus.Instruction;
    assign w_wdata.pc4   = bus.PC_plus_4;
    assign w_wdata.pc8   = bus.PC_plus_8;

    if_id_entry_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_push & ~reset),
        .i_waddr (r_wptr),
        .i_wdata (w_wdata),
        .i_raddr (r_rptr),
        .o_rdata (w_rdata)
    );

    // Pointer and occupancy update; reset beats flush beats push/pop.
    always_ff @(posedge clk) begin
        if (reset || bus.flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= 3'd0;
        end else begin
            if (w_push) begin
                r_wptr <= (r_wptr == LAST) ? '0 : r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= (r_rptr == LAST) ? '0 : r_rptr + 1'b1;
            end
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 3'd1;
                2'b01:   r_count <= r_count - 3'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign bus.in_ready    = ~w_full;
    assign bus.out_valid   = ~w_empty;
    assign bus.count       = r_count;
    assign bus.Instr_D     = w_empty ? NOP   : w_rdata.instr;
    assign bus.PC_plus_4_D = w_empty ? '0    : w_rdata.pc4;
    assign bus.PC_plus_8_D = w_empty ? '0    : w_rdata.pc8;

endmodule

// File: tb/tb_if_id_queue.sv
// Directed bench for if_id_queue: reset, latency, stall/full,
// streaming with pointer wrap, flush and reset-over-flush.
module tb_if_id_queue;

    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;

    if_id_queue_if bus ();

    if_id_queue #(
        .DEPTH (2),
        .NOP   (32'h0000_0000)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [31:0] ins, input logic [31:0] pc4);
        bus.in_valid    = 1'b1;
        bus.Instruction = ins;
        bus.PC_plus_4   = pc4;
        bus.PC_plus_8   = pc4 + 32'd4;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset           = 1'b1;
        bus.Instruction = '0;
        bus.PC_plus_4   = '0;
        bus.PC_plus_8   = '0;
        bus.in_valid    = 1'b0;
        bus.flush       = 1'b0;
        bus.out_ready   = 1'b0;
        tick();
        tick();
        reset = 1'b0;

        chk("rst_count", 32'(bus.count), 32'd0);
        chk("rst_ovalid", 32'(bus.out_valid), 32'd0);
        chk("rst_iready", 32'(bus.in_ready), 32'd1);
        chk("rst_instr", bus.Instr_D, 32'h0);
        chk("rst_pc4", bus.PC_plus_4_D, 32'h0);
        chk("rst_pc8", bus.PC_plus_8_D, 32'h0);

        // single push, one-cycle latency
        offer(32'h2008_0005, 32'h3004);
        tick();
        bus.in_valid = 1'b0;
        chk("lat_ovalid", 32'(bus.out_valid), 32'd1);
        chk("lat_instr", bus.Instr_D, 32'h2008_0005);
        chk("lat_pc4", bus.PC_plus_4_D, 32'h3004);
        chk("lat_pc8", bus.PC_plus_8_D, 32'h3008);
        chk("lat_count", 32'(bus.count), 32'd1);

        // drain, then pop attempts on empty queue
        bus.out_ready = 1'b1;
        tick();
        chk("drain_count", 32'(bus.count), 32'd0);
        tick();
        chk("empty_count", 32'(bus.count), 32'd0);
        chk("empty_ovalid", 32'(bus.out_valid), 32'd0);
        chk("empty_instr", bus.Instr_D, 32'h0);
        chk("empty_pc8", bus.PC_plus_8_D, 32'h0);

        // decode stall: A, B fill, C held off, then ordered drain
        bus.out_ready = 1'b0;
        offer(32'hA000_000A, 32'h100);
        tick();
        chk("stall_cnt1", 32'(bus.count), 32'd1);
        offer(32'hB000_000B, 32'h104);
        tick();
        chk("stall_cnt2", 32'(bus.count), 32'd2);
        chk("stall_irdy", 32'(bus.in_ready), 32'd0);
        offer(32'hC000_000C, 32'h108);
        tick();
        chk("full_cnt", 32'(bus.count), 32'd2);
        chk("full_headA", bus.Instr_D, 32'hA000_000A);
        bus.out_ready = 1'b1;
        tick();
        chk("pop_headB", bus.Instr_D, 32'hB000_000B);
        chk("pop_cnt1", 32'(bus.count), 32'd1);
        tick();
        bus.in_valid = 1'b0;
        chk("pop_headC", bus.Instr_D, 32'hC000_000C);
        chk("pop_pc8C", bus.PC_plus_8_D, 32'h10C);
        chk("pop_cntC", 32'(bus.count), 32'd1);
        tick();
        chk("pop_done", 32'(bus.count), 32'd0);

        // steady stream across pointer wrap
        bus.out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            offer(32'h1000 + 32'(i), 32'h3004 + 32'(4 * i));
            tick();
            chk("strm_cnt", 32'(bus.count), 32'd1);
            chk("strm_pc4", bus.PC_plus_4_D, 32'h3004 + 32'(4 * i));
            chk("strm_ins", bus.Instr_D, 32'h1000 + 32'(i));
        end
        bus.in_valid = 1'b0;
        tick();
        chk("strm_end", 32'(bus.count), 32'd0);

        // flush a full queue with push and pop requested
        bus.out_ready = 1'b0;
        offer(32'h1111_1111, 32'h200);
        tick();
        offer(32'h2222_2222, 32'h204);
        tick();
        chk("fl_full", 32'(bus.count), 32'd2);
        offer(32'h3333_3333, 32'h208);
        bus.out_ready = 1'b1;
        bus.flush     = 1'b1;
        tick();
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        chk("fl_count", 32'(bus.count), 32'd0);
        chk("fl_ovalid", 32'(bus.out_valid), 32'd0);
        chk("fl_instr", bus.Instr_D, 32'h0);
        chk("fl_irdy", 32'(bus.in_ready), 32'd1);

        // reset together with flush on a full queue
        bus.out_ready = 1'b0;
        offer(32'h4444_4444, 32'h300);
        tick();
        offer(32'h5555_5555, 32'h304);
        tick();
        chk("rf_full", 32'(bus.count), 32'd2);
        offer(32'h6666_6666, 32'h308);
        bus.out_ready = 1'b1;
        bus.flush     = 1'b1;
        reset         = 1'b1;
        tick();
        reset        = 1'b0;
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        chk("rf_count", 32'(bus.count), 32'd0);
        chk("rf_ovalid", 32'(bus.out_valid), 32'd0);
        chk("rf_irdy", 32'(bus.in_ready), 32'd1);
        chk("rf_instr", bus.Instr_D, 32'h0);
        chk("rf_pc4", bus.PC_plus_4_D, 32'h0);
        offer(32'h8C09_0000, 32'h500);
        tick();
        bus.in_valid = 1'b0;
        chk("rf_push_cnt", 32'(bus.count), 32'd1);
        chk("rf_push_ins", bus.Instr_D, 32'h8C09_0000);
        chk("rf_push_pc4", bus.PC_plus_4_D, 32'h500);
        bus.out_ready = 1'b1;
        tick();
        chk("rf_alone", 32'(bus.count), 32'd0);
        chk("rf_alone_ins", bus.Instr_D, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
